mdu_seq: RTL and testbench

//  Iterative multiply/divide unit that owns the HI/LO registers.
//  It handles MULT/MULTU/DIV/DIVU/MTHI/MTLO issued from EX and asserts a stall request

---
 rtl/mdu_seq.sv | 234 +++++++++++++++++++++++
 tb/tb_mdu_seq.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_seq.sv
// mdu_seq: iterative multiply/divide unit owning the HI/LO registers.
//   One shared (WIDTH+1)-bit adder serves both the multiply (shift/add,
//   one multiplier bit per cycle) and the restoring divide (shift/subtract,
//   one quotient bit per cycle). A FIX cycle applies signs and writes HI/LO.
//
// Ports
//   clk      rising-edge clock
//   rst      asynchronous active-high reset
//   start    issue the operation in op this cycle
//   op       0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 no-op
//   a, b     rs / rt operands
//   flush    cancel any in-flight operation (wins over start)
//   rd_hilo  instruction in EX reads HI or LO
//   busy     multiply/divide/fix in progress (registered)
//   stall    busy & rd_hilo (combinational)
//   done     one-cycle pulse on the edge HI/LO take a mult/div result
//   hi, lo   HI and LO registers
module mdu_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    input  logic             rd_hilo,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;
    localparam int unsigned PW = 2 * WIDTH;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIX  = 2'd3
    } state_t;

    state_t            state;
    logic [CW-1:0]     cnt;
    // MUL: acc = upper product half, low = multiplier (shifts out LSB first),
    //      opnd = multiplicand.
    // DIV: acc = partial remainder, low = dividend shifting into quotient,
    //      opnd = divisor.
    logic [WIDTH-1:0]  acc;
    logic [WIDTH-1:0]  low;
    logic [WIDTH-1:0]  opnd;
    logic              is_div;
    logic              neg_lo;     // negate product / quotient in FIX
    logic              neg_hi;     // remainder takes the dividend's sign
    logic              div_zero;

    // Operand sign handling at issue time
    logic              op_signed;
    logic              a_neg;
    logic              b_neg;
    logic [WIDTH-1:0]  a_mag;
    logic [WIDTH-1:0]  b_mag;

    always_comb begin
        op_signed = (op == OP_MULT) || (op == OP_DIV);
        a_neg     = op_signed & a[WIDTH-1];
        b_neg     = op_signed & b[WIDTH-1];
        a_mag     = a_neg ? (~a + WIDTH'(1)) : a;
        b_mag     = b_neg ? (~b + WIDTH'(1)) : b;
    end

    // Shared adder: acc + multiplicand in MUL, shifted remainder - divisor in DIV
    logic [WIDTH:0] add_x;
    logic [WIDTH:0] add_y;
    logic           add_cin;
    logic [WIDTH:0] add_sum;

    always_comb begin
        add_x   = {1'b0, acc};
        add_y   = low[0] ? {1'b0, opnd} : '0;
        add_cin = 1'b0;
        if (state == S_DIV) begin
            add_x   = {acc, low[WIDTH-1]};
            add_y   = ~{1'b0, opnd};
            add_cin = 1'b1;
        end
        add_sum = add_x + add_y + {{WIDTH{1'b0}}, add_cin};
    end

    // Remainder >= divisor exactly when the subtraction leaves the top bit clear
    logic rem_ge;
    assign rem_ge = ~add_sum[WIDTH];

    // Sign fix-up of the finished magnitude result
    logic [PW-1:0]    prod_mag;
    logic [PW-1:0]    prod_fix;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;
    logic [WIDTH-1:0] fix_hi;
    logic [WIDTH-1:0] fix_lo;

    always_comb begin
        prod_mag = {acc, low};
        prod_fix = neg_lo ? (~prod_mag + PW'(1)) : prod_mag;
        quo_fix  = neg_lo ? (~low + WIDTH'(1)) : low;
        rem_fix  = neg_hi ? (~acc + WIDTH'(1)) : acc;
        // Divide by zero: quotient forced to all ones; the remainder path
        // already reproduces the original dividend (|a| with a's sign).
        if (div_zero) begin
            quo_fix = '1;
        end
        if (is_div) begin
            fix_hi = rem_fix;
            fix_lo = quo_fix;
        end else begin
            fix_hi = prod_fix[PW-1:WIDTH];
            fix_lo = prod_fix[WIDTH-1:0];
        end
    end

    assign stall = busy & rd_hilo;

    // Sequencer, datapath registers and HI/LO
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            acc      <= '0;
            low      <= '0;
            opnd     <= '0;
            is_div   <= 1'b0;
            neg_lo   <= 1'b0;
            neg_hi   <= 1'b0;
            div_zero <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            done <= 1'b0;
            if (flush) begin
                // Cancels any in-flight op, including its FIX write, and
                // discards a same-cycle start.
                state <= S_IDLE;
                busy  <= 1'b0;
                cnt   <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            case (op)
                                OP_MULT, OP_MULTU: begin
                                    acc      <= '0;
                                    low      <= b_mag;
                                    opnd     <= a_mag;
                                    is_div   <= 1'b0;
                                    neg_lo   <= a_neg ^ b_neg;
                                    neg_hi   <= 1'b0;
                                    div_zero <= 1'b0;
                                    cnt      <= '0;
                                    busy     <= 1'b1;
                                    state    <= S_MUL;
                                end
                                OP_DIV, OP_DIVU: begin
                                    acc      <= '0;
                                    low      <= a_mag;
                                    opnd     <= b_mag;
                                    is_div   <= 1'b1;
                                    neg_lo   <= a_neg ^ b_neg;
                                    neg_hi   <= a_neg;
                                    div_zero <= (b == '0);
                                    cnt      <= '0;
                                    busy     <= 1'b1;
                                    state    <= S_DIV;
                                end
                                OP_MTHI: hi <= a;
                                OP_MTLO: lo <= a;
                                default: ;
                            endcase
                        end
                    end
                    S_MUL: begin
                        // {carry, acc + addend, multiplier} shifted right by one
                        acc <= add_sum[WIDTH:1];
                        low <= {add_sum[0], low[WIDTH-1:1]};
                        cnt <= cnt + CW'(1);
                        if (cnt == CW'(WIDTH - 1)) begin
                            state <= S_FIX;
                        end
                    end
                    S_DIV: begin
                        // Restoring step: keep the difference only if it did not go negative
                        acc <= rem_ge ? add_sum[WIDTH-1:0] : add_x[WIDTH-1:0];
                        low <= {low[WIDTH-2:0], rem_ge};
                        cnt <= cnt + CW'(1);
                        if (cnt == CW'(WIDTH - 1)) begin
                            state <= S_FIX;
                        end
                    end
                    S_FIX: begin
                        hi    <= fix_hi;
                        lo    <= fix_lo;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        cnt   <= '0;
                        state <= S_IDLE;
                    end
                    default: begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    // The pipeline never issues a real op while the unit is busy
    always_ff @(posedge clk) begin
        if (!rst && start && !flush && busy) begin
            assert (op > OP_MTLO);
        end
    end

endmodule

// File: tb/tb_mdu_seq.sv
// tb_mdu_seq: directed testbench for mdu_seq (WIDTH = 32).
//   Inputs are driven on the falling edge; outputs are sampled on the
//   falling edge, half a cycle after the rising edge that updated them.
module tb_mdu_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        rd_hilo;
    logic        busy;
    logic        stall;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_cmp = 0;
    int n_err = 0;

    mdu_seq #(.WIDTH(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .flush   (flush),
        .rd_hilo (rd_hilo),
        .busy    (busy),
        .stall   (stall),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one op at the current falling edge and wait (bounded) for done.
    // cyc = rising edges from acceptance to done (0 on timeout);
    // gap = busy was seen low before done.
    task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          output int cyc, output bit gap);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0; op = 3'd6;
        gap = !busy;
        cyc = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (done) begin
                cyc = k;
                break;
            end
            if (!busy) gap = 1'b1;
        end
    endtask

    task automatic test_reset();
        #12;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
        n_cmp++; if ({hi, lo} !== 64'h0) begin n_err++; $display("FAIL reset_hilo: got %h_%h want 0_0", hi, lo); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_mult();
        int cyc; bit gap;
        run_op(3'd0, 32'hFFFF_FFFD, 32'd7, cyc, gap);
        n_cmp++; if (cyc !== 33) begin n_err++; $display("FAIL mult_latency: got %0d want 33", cyc); end
        n_cmp++; if (gap !== 1'b0) begin n_err++; $display("FAIL mult_busy_hold: busy dropped early"); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL mult_busy_end: got %b want 0", busy); end
        n_cmp++; if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFEB) begin n_err++; $display("FAIL mult_result: got %h_%h want ffffffff_ffffffeb", hi, lo); end
        @(negedge clk);
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL done_pulse_width: got %b want 0", done); end
        run_op(3'd1, 32'hFFFF_FFFD, 32'd7, cyc, gap);
        n_cmp++; if ({hi, lo} !== 64'h0000_0006_FFFF_FFEB) begin n_err++; $display("FAIL multu_result: got %h_%h want 00000006_ffffffeb", hi, lo); end
    endtask

    task automatic test_div();
        int cyc; bit gap;
        run_op(3'd3, 32'd100, 32'd7, cyc, gap);
        n_cmp++; if (cyc !== 33) begin n_err++; $display("FAIL divu_latency: got %0d want 33", cyc); end
        n_cmp++; if ({hi, lo} !== {32'd2, 32'd14}) begin n_err++; $display("FAIL divu_100_7: got %h_%h want 00000002_0000000e", hi, lo); end
        run_op(3'd2, 32'hFFFF_FFF9, 32'd2, cyc, gap);
        n_cmp++; if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFD) begin n_err++; $display("FAIL div_m7_2: got %h_%h want ffffffff_fffffffd", hi, lo); end
        run_op(3'd2, 32'd7, 32'hFFFF_FFFE, cyc, gap);
        n_cmp++; if ({hi, lo} !== 64'h0000_0001_FFFF_FFFD) begin n_err++; $display("FAIL div_7_m2: got %h_%h want 00000001_fffffffd", hi, lo); end
    endtask

    task automatic test_div_edge();
        int cyc; bit gap;
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, cyc, gap);
        n_cmp++; if ({hi, lo} !== 64'h0000_0000_8000_0000) begin n_err++; $display("FAIL div_intmin_m1: got %h_%h want 00000000_80000000", hi, lo); end
        run_op(3'd3, 32'd5, 32'd0, cyc, gap);
        n_cmp++; if (cyc !== 33) begin n_err++; $display("FAIL divu_zero_latency: got %0d want 33", cyc); end
        n_cmp++; if ({hi, lo} !== 64'h0000_0005_FFFF_FFFF) begin n_err++; $display("FAIL divu_5_0: got %h_%h want 00000005_ffffffff", hi, lo); end
        run_op(3'd2, 32'hFFFF_FFFB, 32'd0, cyc, gap);
        n_cmp++; if ({hi, lo} !== 64'hFFFF_FFFB_FFFF_FFFF) begin n_err++; $display("FAIL div_m5_0: got %h_%h want fffffffb_ffffffff", hi, lo); end
    endtask

    task automatic test_mtxx();
        start = 1'b1; op = 3'd4; a = 32'h1234;
        @(negedge clk);
        n_cmp++; if (hi !== 32'h1234) begin n_err++; $display("FAIL mthi: got %h want 00001234", hi); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL mthi_busy: got %b want 0", busy); end
        op = 3'd5; a = 32'h5678;
        @(negedge clk);
        n_cmp++; if ({hi, lo} !== {32'h1234, 32'h5678}) begin n_err++; $display("FAIL mtlo: got %h_%h want 00001234_00005678", hi, lo); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL mtlo_busy: got %b want 0", busy); end
        op = 3'd6; a = 32'hFFFF; b = 32'h3;
        @(negedge clk);
        op = 3'd7;
        @(negedge clk);
        n_cmp++; if ({busy, hi, lo} !== {1'b0, 32'h1234, 32'h5678}) begin n_err++; $display("FAIL noop: got %b %h_%h want 0 00001234_00005678", busy, hi, lo); end
        flush = 1'b1; op = 3'd4; a = 32'hDEAD;
        @(negedge clk);
        flush = 1'b0; start = 1'b0; op = 3'd6;
        n_cmp++; if (hi !== 32'h1234) begin n_err++; $display("FAIL flush_mthi: got %h want 00001234", hi); end
    endtask

    task automatic test_stall();
        int cyc; int bad;
        cyc = 0; bad = 0;
        start = 1'b1; op = 3'd0; a = 32'd5; b = 32'd6;
        @(negedge clk);
        start = 1'b0; op = 3'd6;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 2) rd_hilo = 1'b1;
            #1;
            if (done) begin
                cyc = k;
                if (stall !== 1'b0) bad++;
                break;
            end
            if (k >= 2 && stall !== 1'b1) bad++;
        end
        rd_hilo = 1'b0;
        n_cmp++; if (cyc !== 33) begin n_err++; $display("FAIL stall_op_latency: got %0d want 33", cyc); end
        n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL stall_window: got %0d wrong cycles want 0", bad); end
        n_cmp++; if ({hi, lo} !== {32'd0, 32'd30}) begin n_err++; $display("FAIL mult_5_6: got %h_%h want 00000000_0000001e", hi, lo); end
    endtask

    task automatic test_flush();
        int dones;
        start = 1'b1; op = 3'd0; a = 32'hFFFF_FFFD; b = 32'd7;
        @(negedge clk);
        start = 1'b0; op = 3'd6;
        for (int k = 1; k <= 10; k++) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        n_cmp++; if ({busy, done} !== 2'b00) begin n_err++; $display("FAIL flush_mul_busy: got busy=%b done=%b want 0 0", busy, done); end
        dones = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) dones++;
        end
        n_cmp++; if (dones !== 0) begin n_err++; $display("FAIL flush_mul_done: got %0d pulses want 0", dones); end
        n_cmp++; if ({hi, lo} !== {32'd0, 32'd30}) begin n_err++; $display("FAIL flush_mul_hilo: got %h_%h want 00000000_0000001e", hi, lo); end
        // Flush landing on the FIX cycle must suppress the write
        start = 1'b1; op = 3'd1; a = 32'd2; b = 32'd3;
        @(negedge clk);
        start = 1'b0; op = 3'd6;
        for (int k = 1; k <= 32; k++) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        n_cmp++; if ({busy, done, hi, lo} !== {2'b00, 32'd0, 32'd30}) begin n_err++; $display("FAIL flush_fix: got busy=%b done=%b %h_%h want 0 0 00000000_0000001e", busy, done, hi, lo); end
    endtask

    task automatic test_reset_mid();
        int cyc; bit gap;
        start = 1'b1; op = 3'd4; a = 32'hAAAA;
        @(negedge clk);
        op = 3'd5; a = 32'h5555;
        @(negedge clk);
        op = 3'd3; a = 32'd100; b = 32'd7;
        @(negedge clk);
        start = 1'b0; op = 3'd6;
        for (int k = 1; k <= 15; k++) @(negedge clk);
        n_cmp++; if ({busy, hi, lo} !== {1'b1, 32'hAAAA, 32'h5555}) begin n_err++; $display("FAIL pre_rst_state: got %b %h_%h want 1 0000aaaa_00005555", busy, hi, lo); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if ({busy, hi, lo} !== 65'd0) begin n_err++; $display("FAIL async_rst: got %b %h_%h want 0 0_0", busy, hi, lo); end
        #1 rst = 1'b0;
        @(negedge clk);
        run_op(3'd1, 32'd2, 32'd3, cyc, gap);
        n_cmp++; if ({hi, lo} !== {32'd0, 32'd6}) begin n_err++; $display("FAIL multu_after_rst: got %h_%h want 00000000_00000006", hi, lo); end
    endtask

    task automatic test_back_to_back();
        int cyc; bit gap;
        run_op(3'd3, 32'd100, 32'd7, cyc, gap);
        n_cmp++; if (lo !== 32'd14) begin n_err++; $display("FAIL b2b_first: got %h want 0000000e", lo); end
        run_op(3'd1, 32'hFFFF_FFFD, 32'd7, cyc, gap);
        n_cmp++; if (cyc !== 33) begin n_err++; $display("FAIL b2b_latency: got %0d want 33", cyc); end
        n_cmp++; if ({hi, lo} !== 64'h0000_0006_FFFF_FFEB) begin n_err++; $display("FAIL b2b_second: got %h_%h want 00000006_ffffffeb", hi, lo); end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; op = 3'd6; a = '0; b = '0;
        flush = 1'b0; rd_hilo = 1'b0;
        test_reset();
        test_mult();
        test_div();
        test_div_edge();
        test_mtxx();
        test_stall();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
